// File: rtl/huffman_block_sequencer.sv
// Sequences one 8x8 entropy-coded block: feeds symbol bits to the Huffman decoder, captures magnitude bits,
// tracks the zig-zag index and emits coefficient records. HUFF_SEQ_EXTEND_EN selects signed EXTEND output.
module huffman_block_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic        dec_next_bit,
    output logic        dec_is_new,
    output logic        dec_ac_dc_flag,
    input  logic [3:0]  dec_s_value,
    input  logic [3:0]  dec_r_value,
    input  logic        dec_done,
    output logic        coef_valid,
    output logic [5:0]  coef_index,
    output logic [3:0]  coef_run,
    output logic [3:0]  coef_size,
    output logic [11:0] coef_value,
    output logic        block_done,
    output logic        busy,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, DC_SYM, DC_MAG, AC_SYM, AC_MAG, DONE, ERROR} state_t;

    state_t      state_q, state_d;
    logic [6:0]  index_q, index_d;
    logic [4:0]  sym_cnt_q, sym_cnt_d;
    logic [3:0]  mag_cnt_q, mag_cnt_d;
    logic [9:0]  mag_sr_q, mag_sr_d;
    logic [3:0]  run_q, run_d;
    logic [3:0]  size_q, size_d;
    logic        coef_valid_q, coef_valid_d;
    logic [5:0]  coef_index_q, coef_index_d;
    logic [3:0]  coef_run_q, coef_run_d;
    logic [3:0]  coef_size_q, coef_size_d;
    logic [11:0] coef_value_q, coef_value_d;
    logic        block_done_q, block_done_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic        flag_q, flag_d;

    logic        sym_state, decode_cyc, xfer;
    logic [6:0]  ac_index, zrl_index;
    logic [3:0]  mag_cnt_inc;
    logic [10:0] mag_sr_shift;
    logic [11:0] mag_value;

    // The final magnitude bit is folded in combinationally so the record registers on that transfer.
    assign mag_sr_shift = {mag_sr_q, bit_in};

`ifdef HUFF_SEQ_EXTEND_EN
    always_comb begin
        if (mag_sr_shift[size_q - 4'd1]) begin
            mag_value = {1'b0, mag_sr_shift};
        end else begin
            mag_value = {1'b0, mag_sr_shift} - ((12'd1 << size_q) - 12'd1);
        end
    end
`else
    assign mag_value = {1'b0, mag_sr_shift};
`endif

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        sym_cnt_d    = sym_cnt_q;
        mag_cnt_d    = mag_cnt_q;
        mag_sr_d     = mag_sr_q;
        run_d        = run_q;
        size_d       = size_q;
        coef_valid_d = 1'b0;
        block_done_d = 1'b0;
        coef_index_d = coef_index_q;
        coef_run_d   = coef_run_q;
        coef_size_d  = coef_size_q;
        coef_value_d = coef_value_q;

        sym_state  = (state_q == DC_SYM) || (state_q == AC_SYM);
        decode_cyc = sym_state && (sym_cnt_q != 5'd0) && dec_done;
        bit_ready  = 1'b0;
        if (sym_state) begin
            bit_ready = !decode_cyc && (sym_cnt_q != 5'd16);
        end else if ((state_q == DC_MAG) || (state_q == AC_MAG)) begin
            bit_ready = 1'b1;
        end
        xfer        = bit_valid && bit_ready;
        dec_is_new  = xfer && sym_state;
        ac_index    = index_q + {3'd0, dec_s_value} + 7'd1;
        zrl_index   = index_q + 7'd16;
        mag_cnt_inc = mag_cnt_q + 4'd1;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = DC_SYM;
                    index_d   = 7'd0;
                    sym_cnt_d = 5'd0;
                    mag_cnt_d = 4'd0;
                    mag_sr_d  = 10'd0;
                end
            end
            DC_SYM, AC_SYM: begin
                if (decode_cyc) begin
                    sym_cnt_d = 5'd0;
                    mag_cnt_d = 4'd0;
                    mag_sr_d  = 10'd0;
                    run_d     = dec_s_value;
                    size_d    = dec_r_value;
                    if (state_q == DC_SYM) begin
                        if (dec_r_value > 4'd11) begin
                            state_d = ERROR;
                        end else if (dec_r_value == 4'd0) begin
                            coef_valid_d = 1'b1;
                            coef_index_d = 6'd0;
                            coef_run_d   = 4'd0;
                            coef_size_d  = 4'd0;
                            coef_value_d = 12'd0;
                            state_d      = AC_SYM;
                        end else begin
                            state_d = DC_MAG;
                        end
                    end else if (dec_r_value == 4'd0) begin
                        if (dec_s_value == 4'd0) begin
                            block_done_d = 1'b1;
                            state_d      = DONE;
                        end else if ((dec_s_value == 4'd15) && (zrl_index <= 7'd63)) begin
                            index_d = zrl_index;
                        end else begin
                            state_d = ERROR;
                        end
                    end else if ((ac_index > 7'd63) || (dec_r_value > 4'd10)) begin
                        state_d = ERROR;
                    end else begin
                        index_d = ac_index;
                        state_d = AC_MAG;
                    end
                end else if (sym_cnt_q == 5'd16) begin
                    // No valid code is longer than 16 bits; the decoder has lost sync.
                    state_d = ERROR;
                end else if (xfer) begin
                    sym_cnt_d = sym_cnt_q + 5'd1;
                end
            end
            DC_MAG, AC_MAG: begin
                if (xfer) begin
                    mag_sr_d  = mag_sr_shift[9:0];
                    mag_cnt_d = mag_cnt_inc;
                    if (mag_cnt_inc == size_q) begin
                        coef_valid_d = 1'b1;
                        coef_index_d = index_q[5:0];
                        coef_run_d   = (state_q == AC_MAG) ? run_q : 4'd0;
                        coef_size_d  = size_q;
                        coef_value_d = mag_value;
                        sym_cnt_d    = 5'd0;
                        if ((state_q == AC_MAG) && (index_q == 7'd63)) begin
                            block_done_d = 1'b1;
                            state_d      = DONE;
                        end else begin
                            state_d = AC_SYM;
                        end
                    end
                end
            end
            default: ;
        endcase

        busy_d  = (state_d == DC_SYM) || (state_d == DC_MAG) || (state_d == AC_SYM) || (state_d == AC_MAG);
        error_d = (state_d == ERROR);
        flag_d  = (state_d == DC_SYM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            index_q      <= 7'd0;
            sym_cnt_q    <= 5'd0;
            mag_cnt_q    <= 4'd0;
            mag_sr_q     <= 10'd0;
            run_q        <= 4'd0;
            size_q       <= 4'd0;
            coef_valid_q <= 1'b0;
            coef_index_q <= 6'd0;
            coef_run_q   <= 4'd0;
            coef_size_q  <= 4'd0;
            coef_value_q <= 12'd0;
            block_done_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            flag_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            sym_cnt_q    <= sym_cnt_d;
            mag_cnt_q    <= mag_cnt_d;
            mag_sr_q     <= mag_sr_d;
            run_q        <= run_d;
            size_q       <= size_d;
            coef_valid_q <= coef_valid_d;
            coef_index_q <= coef_index_d;
            coef_run_q   <= coef_run_d;
            coef_size_q  <= coef_size_d;
            coef_value_q <= coef_value_d;
            block_done_q <= block_done_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            flag_q       <= flag_d;
        end
    end

    assign dec_next_bit   = bit_in;
    assign dec_ac_dc_flag = flag_q;
    assign coef_valid     = coef_valid_q;
    assign coef_index     = coef_index_q;
    assign coef_run       = coef_run_q;
    assign coef_size      = coef_size_q;
    assign coef_value     = coef_value_q;
    assign block_done     = block_done_q;
    assign busy           = busy_q;
    assign error          = error_q;
endmodule

// File: tb/tb_huffman_block_sequencer.sv
// Directed bench for huffman_block_sequencer with a length-driven Huffman decoder stub.
module tb_huffman_block_sequencer;
    logic        clk, rst, start, bit_in, bit_valid;
    logic        bit_ready, dec_next_bit, dec_is_new, dec_ac_dc_flag;
    logic [3:0]  dec_s_value, dec_r_value;
    logic        dec_done;
    logic        coef_valid, block_done, busy, error;
    logic [5:0]  coef_index;
    logic [3:0]  coef_run, coef_size;
    logic [11:0] coef_value;

    huffman_block_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .dec_next_bit(dec_next_bit), .dec_is_new(dec_is_new),
        .dec_ac_dc_flag(dec_ac_dc_flag), .dec_s_value(dec_s_value), .dec_r_value(dec_r_value),
        .dec_done(dec_done), .coef_valid(coef_valid), .coef_index(coef_index),
        .coef_run(coef_run), .coef_size(coef_size), .coef_value(coef_value),
        .block_done(block_done), .busy(busy), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HUFF_SEQ_EXTEND_EN
    localparam logic [31:0] T2_VAL = 32'hFFB;
`else
    localparam logic [31:0] T2_VAL = 32'h002;
`endif

    typedef struct { bit dc; int len; logic [3:0] run; logic [3:0] size; } sym_t;
    typedef struct { logic [5:0] idx; logic [3:0] run; logic [3:0] size; logic [11:0] val; int cyc; logic bd; } rec_t;

    sym_t syms [128];
    int   nsyms;
    bit   bits [$];
    rec_t recs [$];
    int   bd_count, bd_cycle, nb_err;
    int   errors = 0;
    int   checks = 0;

    // Decoder stub: answers the queued symbol once its code length worth of strobes has arrived.
    int sp, stub_cnt, flag_err;
    initial flag_err = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_done    <= 1'b0;
            dec_s_value <= 4'd0;
            dec_r_value <= 4'd0;
            stub_cnt    <= 0;
            sp          <= 0;
        end else if (dec_is_new && (sp < nsyms)) begin
            if ((stub_cnt == 0) && (dec_ac_dc_flag !== syms[sp].dc)) flag_err <= flag_err + 1;
            if (stub_cnt + 1 == syms[sp].len) begin
                dec_done    <= 1'b1;
                dec_s_value <= syms[sp].run;
                dec_r_value <= syms[sp].size;
                stub_cnt    <= 0;
                sp          <= sp + 1;
            end else begin
                dec_done <= 1'b0;
                stub_cnt <= stub_cnt + 1;
            end
        end else if (dec_is_new) begin
            dec_done <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({busy, error, block_done, coef_valid, dec_ac_dc_flag, bit_ready, dec_is_new}), 32'd0);
        check({tag, "_rec"}, 32'({coef_index, coef_run, coef_size, coef_value}), 32'd0);
    endtask

    task automatic check_rec(input string tag, input int k, input logic [5:0] idx,
                             input logic [3:0] run, input logic [3:0] sz, input logic [11:0] val);
        if (recs.size() > k) begin
            check({tag, "_idx"},  32'(recs[k].idx),  32'(idx));
            check({tag, "_run"},  32'(recs[k].run),  32'(run));
            check({tag, "_size"}, 32'(recs[k].size), 32'(sz));
            check({tag, "_val"},  32'(recs[k].val),  32'(val));
        end else begin
            check({tag, "_missing"}, recs.size(), k + 1);
        end
    endtask

    task automatic add_sym(input bit dc, input int len, input logic [3:0] run, input logic [3:0] size);
        syms[nsyms] = '{dc, len, run, size};
        nsyms++;
    endtask

    task automatic add_bits(input int n, input logic [15:0] v);
        for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        repeat (2) @(negedge clk);
        nsyms = 0; bits.delete(); recs.delete(); bd_count = 0; bd_cycle = 0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycle c counts clock edges after the start edge; outputs are sampled on the falling edge.
    task automatic run_block(input int budget, input bit stall);
        int c;
        bit xfer, fin;
        rec_t r;
        c = 0; fin = 0;
        while (!fin && c < budget) begin
            if (bits.size() > 0 && !(stall && $urandom_range(0, 2) == 0)) begin
                bit_valid = 1'b1; bit_in = bits[0];
            end else begin
                bit_valid = 1'b0; bit_in = 1'b0;
            end
            #1;
            xfer = bit_valid && bit_ready;
            if (dec_next_bit !== bit_in) nb_err++;
            @(posedge clk);
            if (xfer) void'(bits.pop_front());
            @(negedge clk);
            c++;
            if (coef_valid) begin
                r.idx = coef_index; r.run = coef_run; r.size = coef_size;
                r.val = coef_value; r.cyc = c; r.bd = block_done;
                recs.push_back(r);
            end
            if (block_done) begin bd_count++; bd_cycle = c; end
            if (block_done || error) fin = 1;
        end
        bit_valid = 1'b0; bit_in = 1'b0;
    endtask

    task automatic load_t3();
        add_sym(1, 2, 4'd0, 4'd0);  add_bits(2, 16'b00);
        add_sym(0, 3, 4'd2, 4'd1);  add_bits(3, 16'b101); add_bits(1, 16'b1);
        add_sym(0, 5, 4'd15, 4'd0); add_bits(5, 16'b11001);
        add_sym(0, 2, 4'd0, 4'd2);  add_bits(2, 16'b01);  add_bits(2, 16'b11);
        add_sym(0, 4, 4'd0, 4'd0);  add_bits(4, 16'b1010);
    endtask

    task automatic check_t3(input string tag);
        check({tag, "_nrec"}, recs.size(), 3);
        check_rec({tag, "_dc"}, 0, 6'd0, 4'd0, 4'd0, 12'd0);
        check_rec({tag, "_r3"}, 1, 6'd3, 4'd2, 4'd1, 12'd1);
        check_rec({tag, "_r20"}, 2, 6'd20, 4'd0, 4'd2, 12'd3);
        check({tag, "_bd"}, bd_count, 1);
    endtask

    task automatic load_t2();
        add_sym(1, 2, 4'd0, 4'd3); add_bits(2, 16'b11); add_bits(3, 16'b010);
        add_sym(0, 4, 4'd0, 4'd0); add_bits(4, 16'b1010);
    endtask

    initial begin
        int bad;
        nb_err = 0; nsyms = 0;
        do_reset();
        check_zero("reset");

        // DC size 0 followed by EOB at full bit rate
        add_sym(1, 2, 4'd0, 4'd0); add_bits(2, 16'b10);
        add_sym(0, 4, 4'd0, 4'd0); add_bits(4, 16'b1100);
        do_start();
        run_block(50, 0);
        check("t1_nrec", recs.size(), 1);
        check_rec("t1", 0, 6'd0, 4'd0, 4'd0, 12'd0);
        if (recs.size() > 0) check("t1_coef_cyc", recs[0].cyc, 3);
        check("t1_bd_cyc", bd_cycle, 8);
        check("t1_done_state", 32'({busy, bit_ready, error}), 32'd0);

        // DC size 3, magnitude 010, then EOB
        do_reset();
        load_t2();
        do_start();
        run_block(50, 0);
        check_rec("t2", 0, 6'd0, 4'd0, 4'd3, T2_VAL[11:0]);
        if (recs.size() > 0) check("t2_coef_cyc", recs[0].cyc, 6);
        check("t2_bd_cyc", bd_cycle, 11);

        // AC run/size, ZRL, EOB
        do_reset();
        load_t3();
        do_start();
        run_block(100, 0);
        check_t3("t3");

        // 63 AC coefficients end the block without EOB
        do_reset();
        add_sym(1, 2, 4'd0, 4'd0); add_bits(2, 16'b00);
        for (int k = 0; k < 63; k++) begin
            add_sym(0, 1, 4'd0, 4'd1); add_bits(1, 16'b0); add_bits(1, 16'b1);
        end
        add_sym(0, 4, 4'd0, 4'd0); add_bits(4, 16'b1010);
        do_start();
        run_block(400, 0);
        check("t4_nrec", recs.size(), 64);
        bad = 0;
        for (int k = 0; k < recs.size(); k++) if (32'(recs[k].idx) != k) bad++;
        check("t4_idx_seq", bad, 0);
        check_rec("t4_last", 63, 6'd63, 4'd0, 4'd1, 12'd1);
        if (recs.size() > 63) check("t4_bd_with_last", 32'(recs[63].bd), 32'd1);
        check("t4_bd_count", bd_count, 1);
        check("t4_eob_left", bits.size(), 4);
        bit_valid = 1'b1; bit_in = 1'b1;
        #1;
        check("t4_ready_done", 32'({bit_ready, dec_is_new, busy}), 32'd0);
        @(negedge clk);
        bit_valid = 1'b0;

        // decoder never answers: ERROR after 16 transfers
        do_reset();
        add_sym(1, 100, 4'd0, 4'd0); add_bits(20, 16'hA5C3);
        do_start();
        run_block(60, 0);
        check("t5_error", 32'(error), 32'd1);
        check("t5_xfers", bits.size(), 4);
        check("t5_ready_busy", 32'({bit_ready, busy}), 32'd0);
        do_start();
        repeat (2) @(negedge clk);
        check("t5_start_ignored", 32'({error, busy}), 32'b10);
        #2 rst = 1'b1;
        #1 check_zero("t5_rst");
        do_reset();

        // random stalls give the same records
        load_t3();
        do_start();
        run_block(300, 1);
        check_t3("t6_stall");

        // reset in the middle of a magnitude phase
        do_reset();
        add_sym(1, 2, 4'd0, 4'd3); add_bits(2, 16'b11); add_bits(1, 16'b0);
        do_start();
        run_block(8, 0);
        check("t6_partial_nrec", recs.size(), 0);
        check("t6_partial_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_zero("t6_rst");
        do_reset();
        load_t2();
        do_start();
        run_block(50, 0);
        check("t6_after_nrec", recs.size(), 1);
        check_rec("t6_after", 0, 6'd0, 4'd0, 4'd3, T2_VAL[11:0]);

        check("dc_flag_at_symbol_start", flag_err, 0);
        check("dec_next_bit_copy", nb_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/huffman_block_sequencer.md
# huffman_block_sequencer

Sequences one 8x8 block of entropy-coded data through the Huffman decoder. It takes a serial bit stream from the byte unstuffer, feeds symbol bits to the decoder with the correct DC/AC table select, and captures the magnitude bits that follow each symbol itself. It tracks the zig-zag coefficient index and emits (index, run, size, value) records to the dequantiser. It sits between the bit-stream front end and the Huffman decoder/dequantiser pair.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new block; sampled only in IDLE or DONE
- bit_in  in  1  next coded bit
- bit_valid  in  1  bit_in valid
- bit_ready  out  1  sequencer accepts bit_in this cycle (transfer = bit_valid & bit_ready)
- dec_next_bit  out  1  bit to decoder (combinational copy of bit_in)
- dec_is_new  out  1  decoder bit strobe; high only on a transfer in DC_SYM/AC_SYM
- dec_ac_dc_flag  out  1  table select: 1 = DC in DC_SYM, 0 = AC otherwise
- dec_s_value  in  4  decoded run
- dec_r_value  in  4  decoded size
- dec_done  in  1  decoder symbol-valid
- coef_valid  out  1  one-cycle pulse; coefficient record valid
- coef_index  out  6  zig-zag index, 0..63
- coef_run  out  4  zero run preceding the coefficient (0 for DC)
- coef_size  out  4  magnitude bit count
- coef_value  out  12  coefficient value (see Configuration)
- block_done  out  1  one-cycle pulse; block finished
- busy  out  1  high in every state except IDLE, DONE and ERROR
- error  out  1  sticky error flag

## Operation
- States: IDLE, DC_SYM, DC_MAG, AC_SYM, AC_MAG, DONE, ERROR.
- On start in IDLE or DONE, go to DC_SYM. Clear index, sym_cnt and the magnitude shift register.
- SYM states: a cycle is a decode cycle when sym_cnt > 0 and dec_done = 1. In a decode cycle, bit_ready = 0 and run/size are latched. In all other SYM cycles, bit_ready = 1 and each transfer increments sym_cnt.
- A SYM state goes to ERROR when sym_cnt reaches 16 without dec_done.
- DC decode:
  - size > 11 goes to ERROR.
  - size = 0 emits index 0 with value 0, then goes to AC_SYM.
  - Otherwise go to DC_MAG.
- AC decode:
  - run = 0, size = 0 (EOB): block_done, go to DONE.
  - run = 15, size = 0 (ZRL): index += 16 with no emit. Index > 63 goes to ERROR.
  - Any other size = 0 goes to ERROR.
  - Otherwise index += run + 1. Index > 63 or size > 10 goes to ERROR. Else go to AC_MAG.
- MAG states: bit_ready = 1, dec_is_new = 0. Bits shift in MSB-first. After size transfers, emit the record, clear sym_cnt, and go to AC_SYM.
- After an emit at index 63, assert block_done and go to DONE.
- Index arithmetic uses 7 bits internally, so overflow is detected rather than wrapping.
- ERROR: error = 1, bit_ready = 0. ERROR is left only by rst, because the decoder's bit index cannot recover without its reset. start is ignored in ERROR.
- start while busy is ignored.

## Timing
- All outputs are registered except bit_ready, dec_next_bit and dec_is_new.
- Reset values: every registered output is 0; state = IDLE.
- A symbol of L code bits takes L transfer cycles plus 1 decode cycle. Magnitude bits take 1 cycle each.
- coef_valid is high the cycle after the last magnitude-bit transfer. For a size-0 DC symbol, it is high the cycle after the decode cycle.
- block_done:
  - On EOB, it is high the cycle after the decode cycle.
  - At index 63, it is high in the same cycle as the final coef_valid.
- dec_ac_dc_flag is valid together with the first bit of each symbol; the decoder restarts on that strobe because dec_done is still high.
- bit_valid low stalls any state indefinitely with no side effects.
- rst asserted mid-block returns to IDLE immediately; any partial record is discarded.

## Configuration
- HUFF_SEQ_EXTEND_EN defined: coef_value is the signed JPEG EXTEND of the raw bits. If the raw MSB is 0, value = raw − (2^size − 1); otherwise value = raw. The result is sign-extended to 12 bits.
- Undefined: coef_value is the raw magnitude bits, zero-extended to 12 bits.

## Test plan
- DC size-0 plus EOB, using a decoder stub that answers DC(0/0) after 2 bits and AC EOB after 4 bits: expect coef_valid at index 0 with value 0, then block_done; 8 cycles total at full bit rate.
- DC size 3 with magnitude bits 010, then EOB: expect index 0, coef_value 0x002 without the macro and 0xFFB (−5) with HUFF_SEQ_EXTEND_EN.
- AC run 2 size 1 with bit 1, then ZRL, then run 0 size 2 with bits 11, then EOB: expect records at index 3 (value 1) and index 20 (value 3); no record for the ZRL.
- 63 AC symbols of run 0 size 1: expect block_done together with the index-63 coef_valid, no EOB consumed, and bit_ready low in DONE.
- Stub never asserts dec_done: expect ERROR after 16 transfers, error = 1, bit_ready = 0, and start ignored; rst clears everything to 0.
- Toggle bit_valid randomly and assert rst in the middle of a magnitude phase: records are identical to the stall-free run, and rst gives IDLE with all outputs 0 in the same cycle.
